ltssm_lane_agg: RTL and testbench
=================================

# ltssm_lane_agg

Parametrised lane-aggregation block between the per-lane TS generator/analyser pairs and the core LTSSM state machine. It replaces a fixed 4-lane combinational AND of per-lane handshakes with a latched active-lane mask and sticky per-lane ack collection. It adds a programmable ack timeout that reports the failing lanes, and registered link-width reporting. Inactive (undetected) lanes are excluded from every aggregate.

## Interface
Parameters:
- NUM_LANES, 4, number of lanes (1..16)
- TO_W, 16, width of the timeout counter and `timeout_cycles`
- LW_W, $clog2(NUM_LANES+1), width of `link_width`

Ports:
- clk  in  1  system clock, 1 GHz
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- lane_rx_det  in  NUM_LANES  per-lane receiver-detect result
- width_latch  in  1  pulse: capture `lane_rx_det` as the active mask
- active_lanes  out  NUM_LANES  registered active-lane mask
- link_width  out  LW_W  popcount of `active_lanes`
- ts_update  in  1  pulse from core FSM: new ts_info broadcast to lanes
- ack_tx  in  NUM_LANES  per-lane ts_gen update ack
- ack_rx  in  NUM_LANES  per-lane tsa update ack
- ts_update_ack  out  1  one-cycle pulse: all active lanes acked (tx and rx)
- timeout_cycles  in  TO_W  ack timeout in cycles; 0 disables the timeout
- ack_timeout  out  1  one-cycle pulse: collection timed out
- failed_lanes  out  NUM_LANES  active lanes lacking tx or rx ack at timeout
- busy  out  1  collection in progress
- tsa_p2c_lane, tsa_p_a2c_lane  in  NUM_LANES each  per-lane analyser qualifiers
- tsa_p2c, tsa_p_a2c  out  1 each  aggregated qualifiers

## Operation
- FSM states: IDLE, COLLECT, DONE, TMO.
- IDLE:
  - `ts_update` -> COLLECT.
  - `sticky_tx <= ack_tx & active_lanes`, `sticky_rx <= ack_rx & active_lanes`.
  - Timeout counter cleared to 0.
- COLLECT:
  - Sticky registers OR in the masked acks each cycle.
  - complete = &((sticky_tx & sticky_rx) | ~active_lanes), evaluated on registered sticky values. On complete -> DONE.
  - Otherwise, if `timeout_cycles != 0` and counter == `timeout_cycles-1` -> TMO, with `failed_lanes <= active_lanes & ~(sticky_tx & sticky_rx)`.
  - Otherwise the counter increments; it saturates at all-ones.
- DONE: `ts_update_ack=1` for one cycle -> IDLE.
- TMO: `ack_timeout=1` for one cycle -> IDLE. `failed_lanes` holds until the next TMO or reset.
- `busy` = state != IDLE.
- Re-issued `ts_update` in COLLECT restarts collection: sticky registers reload from the current-cycle acks, counter -> 0, state stays COLLECT.
- `ts_update` in DONE or TMO is dropped.
- complete and timeout in the same cycle: complete wins (DONE).
- Empty active mask: complete is true on the first COLLECT cycle.
- `width_latch` is honoured only in IDLE: `active_lanes <= lane_rx_det`, `link_width <= popcount(lane_rx_det)`. In other states it is ignored.
- `width_latch` and `ts_update` in the same IDLE cycle: the new mask is captured, and the sticky registers are seeded with the old mask.
- Aggregated qualifiers, registered every cycle regardless of state:
  - `tsa_p2c <= |active_lanes & &(tsa_p2c_lane | ~active_lanes)`
  - `tsa_p_a2c` is formed the same way from `tsa_p_a2c_lane`.

## Timing
- Reset values (rst=0 at a clk edge): state IDLE. All outputs 0: `active_lanes`, `link_width`, `ts_update_ack`, `ack_timeout`, `failed_lanes`, `busy`, `tsa_p2c`, `tsa_p_a2c`. Sticky registers and counter also 0.
- Reset mid-COLLECT aborts with no ack or timeout pulse.
- Best-case latency: `ts_update` at cycle T with all acks at T -> COLLECT at T+1 -> `ts_update_ack` high at T+2 only -> IDLE at T+3.
- An ack first arriving at cycle A (A > T) -> `ts_update_ack` at A+2.
- Timeout: the last COLLECT cycle is T+timeout_cycles. `ack_timeout` is high at T+timeout_cycles+1, and `failed_lanes` is valid from that cycle.
- `width_latch` at T -> `active_lanes` and `link_width` valid at T+1.
- Qualifier inputs at T -> aggregate outputs at T+1.
- Acks may be level or pulse; sticky capture makes them equivalent. Acks outside COLLECT and outside the `ts_update` cycle are ignored.

## Test plan
- Width latch: NUM_LANES=4, `lane_rx_det=4'b1011`, `width_latch` in IDLE -> `active_lanes=4'b1011`, `link_width=3` next cycle. `width_latch` while busy -> no change.
- Staggered acks: mask 4'b1111; `ts_update` at T; lane k `ack_tx` at T+k and `ack_rx` at T+k+1, as 1-cycle pulses -> single `ts_update_ack` pulse at T+6; `busy` high from T+1 through T+6.
- Masked lane: mask 4'b0111; lane 3 never acks; lanes 0-2 ack at T -> `ts_update_ack` at T+2, no timeout.
- Timeout: mask 4'b1111, `timeout_cycles=10`; lane 2 missing `ack_rx` -> `ack_timeout` at T+11, `failed_lanes=4'b0100`, no `ts_update_ack`. Repeat with `timeout_cycles=0` -> `busy` stays high indefinitely.
- Corner cases:
  - Completion on the final timeout cycle -> DONE, not TMO.
  - `ts_update` re-issued mid-COLLECT -> counter restarts.
  - Empty mask -> ack at T+2.
  - rst=0 mid-COLLECT -> all outputs 0 next cycle.
- Qualifier aggregation: mask 4'b0011, `tsa_p2c_lane=4'b0011` -> `tsa_p2c=1`. `tsa_p2c_lane=4'b0001` -> 0. Mask 0 -> 0.

Source files
------------

// File: rtl/ltssm_lane_agg.sv
// Lane aggregation between per-lane TS generator/analyser pairs and the core LTSSM:
// latched active-lane mask, sticky ack collection with timeout, and qualifier aggregation.
module ltssm_lane_agg #(
  parameter int NUM_LANES = 4,
  parameter int TO_W      = 16,
  parameter int LW_W      = $clog2(NUM_LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] lane_rx_det,
  input  logic                 width_latch,
  output logic [NUM_LANES-1:0] active_lanes,
  output logic [LW_W-1:0]      link_width,
  input  logic                 ts_update,
  input  logic [NUM_LANES-1:0] ack_tx,
  input  logic [NUM_LANES-1:0] ack_rx,
  output logic                 ts_update_ack,
  input  logic [TO_W-1:0]      timeout_cycles,
  output logic                 ack_timeout,
  output logic [NUM_LANES-1:0] failed_lanes,
  output logic                 busy,
  input  logic [NUM_LANES-1:0] tsa_p2c_lane,
  input  logic [NUM_LANES-1:0] tsa_p_a2c_lane,
  output logic                 tsa_p2c,
  output logic                 tsa_p_a2c
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] TMO     = 2'd3;

  logic [1:0]           state;
  logic [NUM_LANES-1:0] sticky_tx;
  logic [NUM_LANES-1:0] sticky_rx;
  logic [NUM_LANES-1:0] ack_tx_m;
  logic [NUM_LANES-1:0] ack_rx_m;
  logic [NUM_LANES-1:0] ack_both;
  logic [TO_W-1:0]      cnt;
  logic                 complete;
  logic                 expired;

  function automatic logic [LW_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [LW_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) n = n + LW_W'(v[i]);
    return n;
  endfunction

  assign ack_tx_m = ack_tx & active_lanes;
  assign ack_rx_m = ack_rx & active_lanes;
  assign ack_both = sticky_tx & sticky_rx;
  // Inactive lanes count as acked, so an empty mask completes immediately.
  assign complete = &(ack_both | ~active_lanes);
  assign expired  = (timeout_cycles != '0) && (cnt == timeout_cycles - TO_W'(1));

  assign ts_update_ack = (state == DONE);
  assign ack_timeout   = (state == TMO);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sticky_tx    <= '0;
      sticky_rx    <= '0;
      cnt          <= '0;
      active_lanes <= '0;
      link_width   <= '0;
      failed_lanes <= '0;
      tsa_p2c      <= 1'b0;
      tsa_p_a2c    <= 1'b0;
    end else begin
      tsa_p2c   <= (|active_lanes) & (&(tsa_p2c_lane | ~active_lanes));
      tsa_p_a2c <= (|active_lanes) & (&(tsa_p_a2c_lane | ~active_lanes));
      case (state)
        IDLE: begin
          // Seeding uses the mask held this cycle, even if width_latch replaces it.
          sticky_tx <= ack_tx_m;
          sticky_rx <= ack_rx_m;
          cnt       <= '0;
          if (width_latch) begin
            active_lanes <= lane_rx_det;
            link_width   <= popcount(lane_rx_det);
          end
          if (ts_update) state <= COLLECT;
        end
        COLLECT: begin
          sticky_tx <= sticky_tx | ack_tx_m;
          sticky_rx <= sticky_rx | ack_rx_m;
          if (ts_update) begin
            sticky_tx <= ack_tx_m;
            sticky_rx <= ack_rx_m;
            cnt       <= '0;
          end else if (complete) begin
            state <= DONE;
          end else if (expired) begin
            state        <= TMO;
            failed_lanes <= active_lanes & ~ack_both;
          end else if (cnt != '1) begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltssm_lane_agg.sv
// Directed bench for ltssm_lane_agg: expected ack/timeout cycles are queued when
// stimulus is driven and matched against DUT pulses by a negedge monitor.
module tb_ltssm_lane_agg;

  typedef struct {
    int         c;
    logic [3:0] f;
  } tmo_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lane_rx_det;
  logic       width_latch;
  logic [3:0] active_lanes;
  logic [2:0] link_width;
  logic       ts_update;
  logic [3:0] ack_tx;
  logic [3:0] ack_rx;
  logic       ts_update_ack;
  logic [15:0] timeout_cycles;
  logic       ack_timeout;
  logic [3:0] failed_lanes;
  logic       busy;
  logic [3:0] tsa_p2c_lane;
  logic [3:0] tsa_p_a2c_lane;
  logic       tsa_p2c;
  logic       tsa_p_a2c;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_ack_q[$];
  tmo_t exp_tmo_q[$];

  ltssm_lane_agg dut (
    .clk            (clk),
    .rst            (rst),
    .lane_rx_det    (lane_rx_det),
    .width_latch    (width_latch),
    .active_lanes   (active_lanes),
    .link_width     (link_width),
    .ts_update      (ts_update),
    .ack_tx         (ack_tx),
    .ack_rx         (ack_rx),
    .ts_update_ack  (ts_update_ack),
    .timeout_cycles (timeout_cycles),
    .ack_timeout    (ack_timeout),
    .failed_lanes   (failed_lanes),
    .busy           (busy),
    .tsa_p2c_lane   (tsa_p2c_lane),
    .tsa_p_a2c_lane (tsa_p_a2c_lane),
    .tsa_p2c        (tsa_p2c),
    .tsa_p_a2c      (tsa_p_a2c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    int   e;
    tmo_t t;
    if (ts_update_ack) begin
      n_tests++;
      assert (exp_ack_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_ack observed cycle=%0d expected no pulse", cyc);
      end
      if (exp_ack_q.size() != 0) begin
        e = exp_ack_q.pop_front();
        assert (cyc === e) else begin
          n_fail++;
          $error("FAIL ack_cycle observed=%0d expected=%0d", cyc, e);
        end
      end
    end
    if (ack_timeout) begin
      n_tests++;
      assert (exp_tmo_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_timeout observed cycle=%0d expected no pulse", cyc);
      end
      if (exp_tmo_q.size() != 0) begin
        t = exp_tmo_q.pop_front();
        assert (cyc === t.c && failed_lanes === t.f) else begin
          n_fail++;
          $error("FAIL timeout observed cycle=%0d failed=%b expected cycle=%0d failed=%b",
                 cyc, failed_lanes, t.c, t.f);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic latch(input logic [3:0] m);
    lane_rx_det = m;
    width_latch = 1'b1;
    step();
    width_latch = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_ack_q.size() != 0 || exp_tmo_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    assert (exp_ack_q.size() == 0 && exp_tmo_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain observed pending=%0d expected=0", exp_ack_q.size() + exp_tmo_q.size());
      exp_ack_q.delete();
      exp_tmo_q.delete();
    end
    step();
  endtask

  initial begin
    int         t0;
    logic [3:0] v;
    rst = 1'b0;
    lane_rx_det = 4'hF;  width_latch = 1'b1;  ts_update = 1'b1;
    ack_tx = 4'hF;  ack_rx = 4'hF;  timeout_cycles = 16'd0;
    tsa_p2c_lane = 4'hF;  tsa_p_a2c_lane = 4'hF;
    step(3);
    check("rst_active", 32'(active_lanes), 32'h0);
    check("rst_width", 32'(link_width), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(ts_update_ack), 32'h0);
    check("rst_tmo", 32'(ack_timeout), 32'h0);
    check("rst_failed", 32'(failed_lanes), 32'h0);
    check("rst_p2c", 32'(tsa_p2c), 32'h0);
    check("rst_pa2c", 32'(tsa_p_a2c), 32'h0);
    lane_rx_det = 4'h0;  width_latch = 1'b0;  ts_update = 1'b0;
    ack_tx = 4'h0;  ack_rx = 4'h0;  tsa_p2c_lane = 4'h0;  tsa_p_a2c_lane = 4'h0;
    rst = 1'b1;
    step();

    // Width latch and qualifier aggregation
    latch(4'b1011);
    check("latch_active", 32'(active_lanes), 32'hB);
    check("latch_width", 32'(link_width), 32'd3);
    latch(4'b0011);
    tsa_p2c_lane = 4'b0011;
    step();
    check("p2c_all_active", 32'(tsa_p2c), 32'h1);
    tsa_p2c_lane = 4'b0001;
    step();
    check("p2c_partial", 32'(tsa_p2c), 32'h0);
    tsa_p_a2c_lane = 4'b0111;
    step();
    check("pa2c_inactive_ignored", 32'(tsa_p_a2c), 32'h1);

    // Staggered pulse acks; width_latch while busy must be ignored
    latch(4'hF);
    timeout_cycles = 16'd0;
    t0 = cyc;
    exp_ack_q.push_back(t0 + 6);
    for (int j = 0; j <= 4; j++) begin
      ts_update = (j == 0);
      v = 4'h0;
      if (j < 4) v[j] = 1'b1;
      ack_tx = v;
      v = 4'h0;
      if (j >= 1) v[j-1] = 1'b1;
      ack_rx = v;
      width_latch = (j == 2);
      lane_rx_det = 4'b0001;
      step();
      check("stagger_busy", 32'(busy), 32'h1);
    end
    ts_update = 1'b0;  ack_tx = 4'h0;  ack_rx = 4'h0;  width_latch = 1'b0;
    step();
    check("stagger_busy_done", 32'(busy), 32'h1);
    step();
    check("stagger_idle", 32'(busy), 32'h0);
    check("latch_while_busy", 32'(active_lanes), 32'hF);
    drain(5);

    // Masked lane 3 never acks
    latch(4'b0111);
    timeout_cycles = 16'd3;
    t0 = cyc;
    exp_ack_q.push_back(t0 + 2);
    ts_update = 1'b1;  ack_tx = 4'b0111;  ack_rx = 4'b0111;
    step();
    ts_update = 1'b0;  ack_tx = 4'h0;  ack_rx = 4'h0;
    drain(10);

    // Timeout with lane 2 missing rx ack
    latch(4'hF);
    timeout_cycles = 16'd10;
    t0 = cyc;
    exp_tmo_q.push_back('{c: t0 + 11, f: 4'b0100});
    ts_update = 1'b1;  ack_tx = 4'hF;  ack_rx = 4'b1011;
    step();
    ts_update = 1'b0;  ack_tx = 4'h0;  ack_rx = 4'h0;
    drain(30);
    step(2);
    check("failed_hold", 32'(failed_lanes), 32'h4);
    check("tmo_idle", 32'(busy), 32'h0);

    // Timeout disabled, then reset aborts the collection
    timeout_cycles = 16'd0;
    ts_update = 1'b1;  ack_tx = 4'hF;  ack_rx = 4'b1011;
    step();
    ts_update = 1'b0;  ack_tx = 4'h0;  ack_rx = 4'h0;
    step(40);
    check("no_timeout_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_active", 32'(active_lanes), 32'h0);
    check("abort_width", 32'(link_width), 32'h0);
    check("abort_failed", 32'(failed_lanes), 32'h0);
    check("abort_pulses", 32'({ts_update_ack, ack_timeout}), 32'h0);
    rst = 1'b1;
    step();

    // Completion on the final timeout cycle wins over timeout
    latch(4'hF);
    timeout_cycles = 16'd5;
    t0 = cyc;
    exp_ack_q.push_back(t0 + 6);
    ts_update = 1'b1;  ack_tx = 4'hF;  ack_rx = 4'b0111;
    step();
    ts_update = 1'b0;  ack_tx = 4'h0;  ack_rx = 4'h0;
    step(3);
    ack_rx = 4'b1000;
    step();
    ack_rx = 4'h0;
    drain(10);

    // Re-issued ts_update restarts the counter and discards earlier acks
    timeout_cycles = 16'd6;
    t0 = cyc;
    exp_tmo_q.push_back('{c: t0 + 10, f: 4'hF});
    ts_update = 1'b1;
    step();
    ts_update = 1'b0;  ack_tx = 4'hF;  ack_rx = 4'b1110;
    step();
    ack_tx = 4'h0;  ack_rx = 4'h0;
    step();
    ts_update = 1'b1;
    step();
    ts_update = 1'b0;
    drain(20);

    // Empty mask: qualifiers forced low, ack at T+2
    latch(4'h0);
    check("empty_width", 32'(link_width), 32'h0);
    tsa_p2c_lane = 4'hF;
    step();
    check("empty_p2c", 32'(tsa_p2c), 32'h0);
    t0 = cyc;
    exp_ack_q.push_back(t0 + 2);
    ts_update = 1'b1;
    step();
    ts_update = 1'b0;
    drain(10);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
